// File: rtl/align_sched.sv
// align_sched: collects one group of N_PP sign-magnitude partial products with
// their signed exponents. It then streams them out one per handshake as aligned
// two's-complement values through a single time-shared shifter/negator.
module align_sched #(
    parameter int N_PP  = 9,
    parameter int EXP_W = 5,
    parameter int PP_W  = 5,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [PP_W-1:0]  in_pp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_pp,
    output logic [3:0]       out_idx,
    output logic             out_last,
    output logic [EXP_W-1:0] out_exp_max,
    output logic             busy
);

    // Derived widths for the alignment datapath: the magnitude is placed at the
    // top of an (OUT_W-1)-bit field so a zero shift gives the largest value,
    // and the extra MSB keeps the positive form non-negative before negation.
    localparam int MAG_W  = PP_W - 1;
    localparam int SH_W   = OUT_W - 1;
    localparam int PAD_W  = SH_W - MAG_W;
    localparam int DIFF_W = EXP_W + 1;

    localparam logic [3:0]        LAST_IDX = 4'(N_PP - 1);
    localparam logic [DIFF_W-1:0] SH_LIMIT = DIFF_W'(SH_W);
    localparam logic [EXP_W-1:0]  EXP_MIN  = {1'b1, {(EXP_W-1){1'b0}}};

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       count_q, count_d;
    logic [3:0]       idx_q, idx_d;
    logic [EXP_W-1:0] exp_max_q, exp_max_d;
    logic             wr_en;

    logic [EXP_W-1:0] buf_exp [N_PP];
    logic [PP_W-1:0]  buf_pp  [N_PP];

    logic [EXP_W-1:0]  rd_exp;
    logic [PP_W-1:0]   rd_pp;
    logic [DIFF_W-1:0] diff;
    logic [SH_W-1:0]   mag_full;
    logic [SH_W-1:0]   shifted;
    logic [OUT_W-1:0]  pp_pos;
    logic [OUT_W-1:0]  pp_neg;
    logic [OUT_W-1:0]  aligned;

    // Control state register; reset and flush both land in an empty COLLECT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= COLLECT;
            count_q   <= '0;
            idx_q     <= '0;
            exp_max_q <= EXP_MIN;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            exp_max_q <= exp_max_d;
        end
    end

    // Next-state logic: accept entries and track the running maximum in COLLECT,
    // advance the read index on each output handshake in EMIT, and let flush override all.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        exp_max_d = exp_max_q;
        wr_en     = 1'b0;

        case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 4'd1;
                    if ((count_q == 4'd0) || ($signed(in_exp) > $signed(exp_max_q))) begin
                        exp_max_d = in_exp;
                    end
                    if (count_q == LAST_IDX) begin
                        state_d = EMIT;
                        count_d = '0;
                        idx_d   = '0;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = COLLECT;
                        count_d = '0;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = COLLECT;
                count_d = '0;
                idx_d   = '0;
            end
        endcase

        if (flush) begin
            state_d = COLLECT;
            count_d = '0;
            idx_d   = '0;
            wr_en   = 1'b0;
        end
    end

    // Entry buffer; contents are meaningless outside a group, so it has no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_exp[count_q] <= in_exp;
            buf_pp[count_q]  <= in_pp;
        end
    end

    assign rd_exp = buf_exp[idx_q];
    assign rd_pp  = buf_pp[idx_q];

    // Shared aligner: shift the magnitude right by (exp_max - exp), then apply the sign.
    always_comb begin
        diff     = {exp_max_q[EXP_W-1], exp_max_q} - {rd_exp[EXP_W-1], rd_exp};
        mag_full = {rd_pp[MAG_W-1:0], {PAD_W{1'b0}}};
        shifted  = (diff >= SH_LIMIT) ? '0 : (mag_full >> diff);
        pp_pos   = {1'b0, shifted};
        pp_neg   = ~pp_pos + OUT_W'(1);
        aligned  = rd_pp[PP_W-1] ? pp_neg : pp_pos;
    end

    assign in_ready    = (state_q == COLLECT);
    assign out_valid   = (state_q == EMIT);
    assign out_pp      = out_valid ? aligned : '0;
    assign out_idx     = out_valid ? idx_q : '0;
    assign out_last    = out_valid && (idx_q == LAST_IDX);
    assign out_exp_max = exp_max_q;
    assign busy        = (state_q == EMIT) || (count_q != 4'd0);

endmodule

// File: tb/tb_align_sched.sv
// tb_align_sched: directed, table-driven bench for align_sched. Inputs change
// and outputs are sampled on the falling clock edge.
module tb_align_sched;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_exp;
    logic [4:0]  in_pp;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pp;
    logic [3:0]  out_idx;
    logic        out_last;
    logic [4:0]  out_exp_max;
    logic        busy;

    typedef struct {
        logic [4:0]  e;
        logic [4:0]  p;
        logic [15:0] q;
    } vec_t;

    vec_t       vecs    [54];
    logic [4:0] grp_max [6];

    int checks = 0;
    int errors = 0;

    align_sched dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_exp     (in_exp),
        .in_pp      (in_pp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pp     (out_pp),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .out_exp_max(out_exp_max),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic setVec(input int k, input logic [4:0] e, input logic [4:0] p, input logic [15:0] q);
        vecs[k].e = e;
        vecs[k].p = p;
        vecs[k].q = q;
    endtask

    // Present one entry and hold it until accepted; returns on the falling edge after the handshake.
    task automatic applyStimulus(input logic [4:0] e, input logic [4:0] p);
        int w;
        in_valid = 1'b1;
        in_exp   = e;
        in_pp    = p;
        w = 0;
        while (!in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (w >= 40) begin
            errors++;
            checks++;
            $display("[TB] FAIL in_ready_timeout: got 0, expected 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic sendGroup(input int g);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[g*9+i].e, vecs[g*9+i].p);
            if (i == 0) checkOutput("busy_after_first", {31'd0, busy}, 32'd1);
        end
        checkOutput("latency_out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("emit_in_ready", {31'd0, in_ready}, 32'd0);
    endtask

    // Drain one group, optionally stalling out_ready at one index while poking in_valid.
    task automatic receiveGroup(input int g, input int stall_idx, input int stall_cycles);
        int w;
        for (int i = 0; i < 9; i++) begin
            w = 0;
            while (!out_valid && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (w >= 20) begin
                errors++;
                checks++;
                $display("[TB] FAIL out_valid_timeout: group %0d idx %0d got 0, expected 1", g, i);
            end
            if (i == stall_idx) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_cycles; s++) begin
                    in_valid = 1'b1;
                    in_exp   = 5'h0F;
                    in_pp    = 5'h1F;
                    @(negedge clk);
                    checkOutput("stall_idx", {28'd0, out_idx}, i);
                    checkOutput("stall_pp", {16'd0, out_pp}, {16'd0, vecs[g*9+i].q});
                    checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    checkOutput("stall_exp_max", {27'd0, out_exp_max}, {27'd0, grp_max[g]});
                end
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            checkOutput("out_idx", {28'd0, out_idx}, i);
            checkOutput("out_pp", {16'd0, out_pp}, {16'd0, vecs[g*9+i].q});
            checkOutput("out_last", {31'd0, out_last}, (i == 8) ? 32'd1 : 32'd0);
            checkOutput("out_exp_max", {27'd0, out_exp_max}, {27'd0, grp_max[g]});
            @(negedge clk);
        end
        checkOutput("back_to_collect", {31'd0, in_ready}, 32'd1);
        checkOutput("no_extra_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic sendDiscarded();
        applyStimulus(5'h01, 5'h0F);
        applyStimulus(5'h0A, 5'h1F);
        applyStimulus(5'h03, 5'h05);
        applyStimulus(5'h1E, 5'h0C);
        applyStimulus(5'h04, 5'h11);
    endtask

    initial begin
        // Group 0: equal exponents, positive product
        for (int i = 0; i < 9; i++) setVec(i, 5'd3, 5'h05, 16'h2800);
        grp_max[0] = 5'd3;
        // Group 1: exponents 0..8, pp=+1
        setVec( 9, 5'h00, 5'h01, 16'h0008);
        setVec(10, 5'h01, 5'h01, 16'h0010);
        setVec(11, 5'h02, 5'h01, 16'h0020);
        setVec(12, 5'h03, 5'h01, 16'h0040);
        setVec(13, 5'h04, 5'h01, 16'h0080);
        setVec(14, 5'h05, 5'h01, 16'h0100);
        setVec(15, 5'h06, 5'h01, 16'h0200);
        setVec(16, 5'h07, 5'h01, 16'h0400);
        setVec(17, 5'h08, 5'h01, 16'h0800);
        grp_max[1] = 5'd8;
        // Group 2: sign handling with equal exponents
        setVec(18, 5'h02, 5'h13, 16'hE800);
        setVec(19, 5'h02, 5'h10, 16'h0000);
        setVec(20, 5'h02, 5'h0F, 16'h7800);
        setVec(21, 5'h02, 5'h01, 16'h0800);
        setVec(22, 5'h02, 5'h11, 16'hF800);
        setVec(23, 5'h02, 5'h08, 16'h4000);
        setVec(24, 5'h02, 5'h18, 16'hC000);
        setVec(25, 5'h02, 5'h1F, 16'h8800);
        setVec(26, 5'h02, 5'h00, 16'h0000);
        grp_max[2] = 5'd2;
        // Group 3: large shifts with exp_max=15
        setVec(27, 5'h10, 5'h0F, 16'h0000);
        setVec(28, 5'h00, 5'h0F, 16'h0000);
        setVec(29, 5'h01, 5'h0F, 16'h0001);
        setVec(30, 5'h01, 5'h1F, 16'hFFFF);
        setVec(31, 5'h0F, 5'h01, 16'h0800);
        setVec(32, 5'h0E, 5'h01, 16'h0400);
        setVec(33, 5'h1F, 5'h0F, 16'h0000);
        setVec(34, 5'h07, 5'h1F, 16'hFF88);
        setVec(35, 5'h0F, 5'h1F, 16'h8800);
        grp_max[3] = 5'h0F;
        // Group 4: all-negative exponents, max -2 not first
        setVec(36, 5'h1D, 5'h01, 16'h0400);
        setVec(37, 5'h1B, 5'h01, 16'h0100);
        setVec(38, 5'h1E, 5'h01, 16'h0800);
        setVec(39, 5'h1E, 5'h01, 16'h0800);
        setVec(40, 5'h18, 5'h01, 16'h0020);
        setVec(41, 5'h1C, 5'h01, 16'h0200);
        setVec(42, 5'h1E, 5'h01, 16'h0800);
        setVec(43, 5'h19, 5'h01, 16'h0040);
        setVec(44, 5'h1A, 5'h01, 16'h0080);
        grp_max[4] = 5'h1E;
        // Group 5: post-abort group, exponents <= 2
        setVec(45, 5'h00, 5'h02, 16'h0400);
        setVec(46, 5'h01, 5'h12, 16'hF800);
        setVec(47, 5'h02, 5'h07, 16'h3800);
        setVec(48, 5'h1F, 5'h04, 16'h0400);
        setVec(49, 5'h02, 5'h19, 16'hB800);
        setVec(50, 5'h00, 5'h0A, 16'h1400);
        setVec(51, 5'h01, 5'h03, 16'h0C00);
        setVec(52, 5'h1D, 5'h0F, 16'h03C0);
        setVec(53, 5'h02, 5'h1C, 16'hA000);
        grp_max[5] = 5'h02;

        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_exp    = 5'h00;
        in_pp     = 5'h00;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_pp", {16'd0, out_pp}, 32'd0);
        checkOutput("rst_out_idx", {28'd0, out_idx}, 32'd0);
        checkOutput("rst_out_last", {31'd0, out_last}, 32'd0);
        checkOutput("rst_exp_max", {27'd0, out_exp_max}, 32'h10);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] table groups");
        for (int g = 0; g < 5; g++) begin
            sendGroup(g);
            receiveGroup(g, -1, 0);
        end

        $display("[TB] backpressure at idx 4");
        sendGroup(1);
        receiveGroup(1, 4, 3);

        $display("[TB] flush during collect");
        sendDiscarded();
        checkOutput("partial_busy", {31'd0, busy}, 32'd1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_exp   = 5'h0C;
        in_pp    = 5'h0F;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush_busy", {31'd0, busy}, 32'd0);
        checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd1);
        sendGroup(5);
        receiveGroup(5, -1, 0);

        $display("[TB] async reset during collect");
        sendDiscarded();
        #2 rst = 1'b0;
        #1;
        checkOutput("async_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("async_rst_exp_max", {27'd0, out_exp_max}, 32'h10);
        checkOutput("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        sendGroup(5);
        receiveGroup(5, -1, 0);

        $display("[TB] flush during emit");
        sendGroup(3);
        repeat (2) @(negedge clk);
        checkOutput("emit_mid_idx", {28'd0, out_idx}, 32'd2);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("emit_flush_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("emit_flush_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("emit_flush_idx", {28'd0, out_idx}, 32'd0);
        checkOutput("emit_flush_busy", {31'd0, busy}, 32'd0);
        sendGroup(4);
        receiveGroup(4, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
